// File: rtl/sysbus_mem_responder.sv
// System-bus memory endpoint: accepts one request at a time, serves 8-beat line
// reads from a line-organised RAM, absorbs 8-beat line writes, and takes preloads.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif
`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 2
`endif

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_LINES      = 1024,
  parameter int RD_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      preload_we,
  input  logic [63:0]               preload_addr,
  input  logic [63:0]               preload_data,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int WORD_W = IDX_W + 3;
  localparam logic [BUS_TAG_WIDTH-13:0] TGT_MEM  = `SYSBUS_MEMORY;
  localparam logic [3:0]                OP_READ  = `SYSBUS_READ;
  localparam logic [3:0]                OP_WRITE = `SYSBUS_WRITE;
  localparam logic [3:0] LAT_LAST = 4'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ACK, RD_WAIT, RD_BURST, WR_DATA} state_t;

  state_t                     state;
  logic [IDX_W-1:0]           line;
  logic [2:0]                 beat;
  logic [3:0]                 wait_cnt;
  logic [BUS_TAG_WIDTH-1:0]   tag;
  logic [BUS_DATA_WIDTH-1:0]  mem [MEM_LINES*8];

  logic [WORD_W-1:0] preload_word;
  logic              bus_write;
  logic              is_mem;
  logic [3:0]        op;
  logic              unused_preload_bits;

  assign preload_word        = preload_addr[6+IDX_W-1:3];
  assign bus_write           = (state == WR_DATA) && bus_reqcyc;
  assign busy                = (state != IDLE);
  assign is_mem              = (tag[BUS_TAG_WIDTH-1:12] == TGT_MEM);
  assign op                  = tag[11:8];
  assign unused_preload_bits = ^{preload_addr[63:6+IDX_W], preload_addr[2:0]};

  // NOTE: the RAM array has no reset; clearing it would defeat block-RAM mapping
  // and reset must leave stored lines intact. The bus write is placed last so it
  // wins over a preload hitting the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (preload_we) mem[preload_word] <= preload_data;
    if (bus_write)  mem[{line, beat}] <= bus_req;
  end

  // The next beat is fetched into bus_resp on the edge the current one
  // transfers, so preloads only affect beats not yet presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      line        <= '0;
      beat        <= '0;
      wait_cnt    <= '0;
      tag         <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_reqcyc) begin
            line       <= bus_req[6+IDX_W-1:6];
            tag        <= bus_reqtag;
            bus_reqack <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          beat     <= '0;
          wait_cnt <= '0;
          if (is_mem && op == OP_READ) begin
            bus_reqack <= 1'b0;
            if (RD_LATENCY == 0) begin
              bus_respcyc <= 1'b1;
              bus_resp    <= mem[{line, 3'd0}];
              bus_resptag <= tag;
              state       <= RD_BURST;
            end else begin
              state <= RD_WAIT;
            end
          end else if (is_mem && op == OP_WRITE) begin
            state <= WR_DATA;
          end else begin
            bus_reqack <= 1'b0;
            state      <= IDLE;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == LAT_LAST) begin
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[{line, 3'd0}];
            bus_resptag <= tag;
            state       <= RD_BURST;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RD_BURST: begin
          if (bus_respack) begin
            if (beat == 3'd7) begin
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              bus_resptag <= '0;
              state       <= IDLE;
            end else begin
              beat     <= beat + 3'd1;
              bus_resp <= mem[{line, beat + 3'd1}];
            end
          end
        end
        WR_DATA: begin
          if (bus_reqcyc) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) begin
              bus_reqack <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: directed and random line
// reads/writes compared against a flat word-array model of the memory.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif
`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 2
`endif

module tb_sysbus_mem_responder;

  localparam int MEM_LINES  = 1024;
  localparam int RD_LATENCY = 4;
  localparam logic [12:0] RD_TAG  = 13'((`SYSBUS_MEMORY << 12) | (`SYSBUS_READ << 8));
  localparam logic [12:0] WR_TAG  = 13'((`SYSBUS_MEMORY << 12) | (`SYSBUS_WRITE << 8));
  localparam logic [12:0] BAD_TGT = RD_TAG ^ 13'h1000;
  localparam logic [12:0] BAD_OP  = 13'((`SYSBUS_MEMORY << 12) | (15 << 8) | 5);

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        preload_we;
  logic [63:0] preload_addr;
  logic [63:0] preload_data;
  logic        busy;

  logic [63:0] model [MEM_LINES*8];
  int n_assert = 0;
  int n_fail   = 0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_LINES(MEM_LINES), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .preload_we(preload_we), .preload_addr(preload_addr), .preload_data(preload_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Model indexing: a line is 8 consecutive words; addresses alias modulo the RAM size.
  function automatic int line_base(input logic [63:0] a);
    return int'((a >> 6) % 64'(MEM_LINES)) * 8;
  endfunction

  task automatic preload_word(input logic [63:0] a, input logic [63:0] d);
    preload_we   = 1'b1;
    preload_addr = a;
    preload_data = d;
    model[int'((a >> 3) % 64'(MEM_LINES * 8))] = d;
    @(negedge clk);
    preload_we = 1'b0;
  endtask

  task automatic issue(input logic [63:0] a, input logic [12:0] t, output int waited);
    bus_reqcyc = 1'b1;
    bus_req    = a;
    bus_reqtag = t;
    waited     = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus_reqack && waited < 50);
  endtask

  // Collects one burst starting at a negedge where beat 0 should be presented.
  task automatic collect(input logic [63:0] a, input int s0, input int s5, input int pl_beat,
                         input string name);
    logic [63:0] exp [8];
    int base, beat, held, total, guard;
    bit pl_done;
    base = line_base(a);
    for (int k = 0; k < 8; k++) exp[k] = model[base + k];
    beat = 0; held = 0; total = 0; guard = 0; pl_done = 0;
    while (beat < 8 && guard < 100) begin
      preload_we = 1'b0;
      check({name, "_data"}, bus_resp, exp[beat]);
      check({name, "_tag"}, 64'(bus_resptag), 64'(RD_TAG));
      check({name, "_noack"}, 64'(bus_reqack), 64'd0);
      if (pl_beat >= 0 && beat == 2 && !pl_done) begin
        logic [63:0] nd;
        nd = {$urandom, $urandom};
        preload_we   = 1'b1;
        preload_addr = (a & ~64'h3F) + 64'(8 * pl_beat);
        preload_data = nd;
        exp[pl_beat] = nd;
        model[base + pl_beat] = nd;
        pl_done = 1;
      end
      if (held < ((beat == 0) ? s0 : (beat == 5) ? s5 : 0)) begin
        bus_respack = 1'b0;
        held++;
      end else begin
        bus_respack = 1'b1;
        held = 0;
        beat++;
      end
      total++;
      guard++;
      @(negedge clk);
    end
    preload_we  = 1'b0;
    bus_respack = 1'b0;
    check({name, "_beats"}, 64'(beat), 64'd8);
    check({name, "_cycles"}, 64'(total), 64'(8 + s0 + s5));
    check({name, "_end_cyc"}, 64'(bus_respcyc), 64'd0);
    check({name, "_end_data"}, bus_resp, 64'd0);
    check({name, "_end_tag"}, 64'(bus_resptag), 64'd0);
    check({name, "_end_busy"}, 64'(busy), 64'd0);
  endtask

  // Called at the negedge where reqack was seen for a read request.
  task automatic rd_tail(input logic [63:0] a, input int s0, input int s5, input int pl_beat,
                         input bit next_en, input logic [63:0] next_addr, input string name);
    int lat;
    @(negedge clk);
    bus_reqcyc = next_en;
    bus_req    = next_addr;
    check({name, "_ack_once"}, 64'(bus_reqack), 64'd0);
    lat = 1;
    while (!bus_respcyc && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(RD_LATENCY + 1));
    collect(a, s0, s5, pl_beat, name);
  endtask

  task automatic read_line(input logic [63:0] a, input int s0, input int s5, input int pl_beat,
                           input string name);
    int w;
    issue(a, RD_TAG, w);
    check({name, "_ackwait"}, 64'(w), 64'd1);
    rd_tail(a, s0, s5, pl_beat, 1'b0, 64'd0, name);
  endtask

  task automatic write_line(input logic [63:0] a, input logic [63:0] d [8], input int gap,
                            input int collide, input string name);
    int w, base;
    base = line_base(a);
    issue(a, WR_TAG, w);
    check({name, "_ackwait"}, 64'(w), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      preload_we = 1'b0;
      if (k == gap) begin
        bus_reqcyc = 1'b0;
        @(negedge clk);
      end
      check({name, "_wr_ack"}, 64'(bus_reqack), 64'd1);
      bus_reqcyc = 1'b1;
      bus_req    = d[k];
      model[base + k] = d[k];
      if (k == collide) begin
        preload_we   = 1'b1;
        preload_addr = (a & ~64'h3F) + 64'(8 * k);
        preload_data = ~d[k];
      end
    end
    @(negedge clk);
    preload_we = 1'b0;
    bus_reqcyc = 1'b0;
    check({name, "_wr_end_ack"}, 64'(bus_reqack), 64'd0);
    check({name, "_wr_end_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] d [8];
    logic [63:0] a;
    int w;
    bit seen;

    reset = 1'b1; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    preload_we = 1'b0; preload_addr = '0; preload_data = '0;
    #1;
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic read of a preloaded line, then the same read with respack stalls
    for (int k = 0; k < 8; k++) preload_word(64'h40 + 64'(8 * k), 64'h1000 + 64'(k));
    read_line(64'h40, 0, 0, -1, "rd_basic");
    read_line(64'h40, 3, 2, -1, "rd_stall");

    // Write with a mid-burst reqcyc gap, then direct and aliased readback
    for (int k = 0; k < 8; k++) d[k] = 64'hA0 + 64'(k);
    write_line(64'h80, d, 4, -1, "wr_gap");
    read_line(64'h80, 0, 0, -1, "rd_wr");
    read_line(64'h80 + 64'(MEM_LINES * 64), 1, 0, -1, "rd_alias");

    // Unaligned read starts from word 0
    read_line(64'h47, 0, 0, -1, "rd_unaligned");

    // Foreign target and unknown opcode are acked and dropped
    issue(64'h40, BAD_TGT, w);
    check("bad_tgt_ackwait", 64'(w), 64'd1);
    check("bad_tgt_busy_ack", 64'(busy), 64'd1);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    check("bad_tgt_busy_done", 64'(busy), 64'd0);
    check("bad_tgt_reqack", 64'(bus_reqack), 64'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_respcyc || busy) seen = 1;
    end
    check("bad_tgt_silent", 64'(seen), 64'd0);
    issue(64'h40, BAD_OP, w);
    check("bad_op_ackwait", 64'(w), 64'd1);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    check("bad_op_busy_done", 64'(busy), 64'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_respcyc || busy) seen = 1;
    end
    check("bad_op_silent", 64'(seen), 64'd0);

    // A second request held during a burst waits for the bubble after it
    issue(64'h40, RD_TAG, w);
    check("busy_first_ackwait", 64'(w), 64'd1);
    rd_tail(64'h40, 1, 1, -1, 1'b1, 64'h80, "busy_first");
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus_reqack && w < 50);
    check("busy_second_ackwait", 64'(w), 64'd1);
    rd_tail(64'h80, 0, 0, -1, 1'b0, 64'd0, "busy_second");

    // Asynchronous reset while beat 3 is presented
    issue(64'h40, RD_TAG, w);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    w = 0;
    while (!bus_respcyc && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus_respack = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_beat3", bus_resp, model[line_base(64'h40) + 3]);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_mid_reqack", 64'(bus_reqack), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_resp", bus_resp, 64'd0);
    bus_respack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_line(64'h40, 0, 0, -1, "rd_after_rst");

    // Bus write beats a same-word preload; a preload mid-burst reaches a later beat
    for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
    write_line(64'h100, d, -1, 2, "wr_collide");
    read_line(64'h100, 0, 0, 6, "rd_collide");
    read_line(64'h100, 0, 0, -1, "rd_after_pl");

    // Random preloaded lines, random writes and random stalls
    for (int r = 0; r < 4; r++) begin
      a = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) preload_word((a & ~64'h3F) + 64'(8 * k), {$urandom, $urandom});
      read_line(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, "rnd_rd");
      a = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
      write_line(a, d, int'($urandom_range(0, 7)), -1, "rnd_wr");
      read_line(a ^ 64'(MEM_LINES * 64), int'($urandom_range(0, 3)), 0, -1, "rnd_wr_rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
